vc_fifo_bank: RTL and testbench

VC_FIFO_BANK -- requirements
Module: vc_fifo_bank

---
 rtl/vc_fifo_bank.sv | 105 ++++++++++
 tb/tb_vc_fifo_bank.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/vc_fifo_bank.sv
// Bank of NCH independent circular FIFOs sharing one write port and one read port.
// Flags and occupancy are decoded combinationally from each channel's registered count.
module vc_fifo_bank #(
  parameter int unsigned BW  = 6,
  parameter int unsigned LEN = 4,
  parameter int unsigned NCH = 2,
  parameter int unsigned TOL = 1
) (
  input  logic                                  clk,
  input  logic                                  reset_L,
  input  logic                                  fifo_wr,
  input  logic [$clog2(NCH)-1:0]                wr_ch,
  input  logic [BW-1:0]                         fifo_data_in,
  input  logic                                  fifo_rd,
  input  logic [$clog2(NCH)-1:0]                rd_ch,
  output logic [BW-1:0]                         fifo_data_out,
  output logic                                  data_valid,
  output logic [NCH-1:0]                        error_output,
  output logic [NCH-1:0]                        fifo_full,
  output logic [NCH-1:0]                        fifo_empty,
  output logic [NCH-1:0]                        fifo_almost_full,
  output logic [NCH-1:0]                        fifo_almost_empty,
  output logic [NCH*($clog2(LEN)+1)-1:0]        occupancy
);

  localparam int unsigned CW = $clog2(NCH);
  localparam int unsigned AW = $clog2(LEN);
  localparam int unsigned OW = AW + 1;

  logic [BW-1:0]  mem    [NCH][LEN];
  logic [AW-1:0]  wr_ptr [NCH];
  logic [AW-1:0]  rd_ptr [NCH];
  logic [OW-1:0]  cnt    [NCH];
  logic [NCH-1:0] wr_sel, rd_sel, wr_ok, rd_ok;
  logic [BW-1:0]  head;

  // Channel decode; out-of-range selects match no channel and become no-ops.
  // A full channel may still take a write when the same channel is read this cycle.
  always_comb begin
    wr_sel = '0;
    rd_sel = '0;
    wr_ok  = '0;
    rd_ok  = '0;
    head   = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_sel[i] = fifo_wr && (wr_ch == CW'(i));
      rd_sel[i] = fifo_rd && (rd_ch == CW'(i));
      rd_ok[i]  = rd_sel[i] && (cnt[i] != '0);
      wr_ok[i]  = wr_sel[i] && ((cnt[i] != OW'(LEN)) || rd_ok[i]);
      if (rd_ok[i]) head = mem[i][rd_ptr[i]];
    end
  end

  // Status decode from the registered counts.
  always_comb begin
    fifo_full         = '0;
    fifo_empty        = '0;
    fifo_almost_full  = '0;
    fifo_almost_empty = '0;
    occupancy         = '0;
    for (int i = 0; i < NCH; i++) begin
      fifo_full[i]         = (cnt[i] == OW'(LEN));
      fifo_empty[i]        = (cnt[i] == '0);
      fifo_almost_full[i]  = (cnt[i] >= OW'(LEN - TOL));
      fifo_almost_empty[i] = (cnt[i] <= OW'(TOL));
      occupancy[i*OW +: OW] = cnt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      fifo_data_out <= '0;
      data_valid    <= 1'b0;
      error_output  <= '0;
      for (int i = 0; i < NCH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      data_valid   <= |rd_ok;
      if (|rd_ok) fifo_data_out <= head;
      error_output <= error_output | (wr_sel & ~wr_ok) | (rd_sel & ~rd_ok);
      for (int i = 0; i < NCH; i++) begin
        if (wr_ok[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (rd_ok[i]) rd_ptr[i] <= rd_ptr[i] + AW'(1);
        case ({wr_ok[i], rd_ok[i]})
          2'b10:   cnt[i] <= cnt[i] + OW'(1);
          2'b01:   cnt[i] <= cnt[i] - OW'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  // Storage is intentionally not reset; pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (reset_L) begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_ok[i]) mem[i][wr_ptr[i]] <= fifo_data_in;
      end
    end
  end

endmodule

// File: tb/tb_vc_fifo_bank.sv
// Bench for vc_fifo_bank: directed scenarios plus random traffic, checked against
// a queue-based reference model of the channel bank.
module tb_vc_fifo_bank;

  localparam int unsigned BW  = 6;
  localparam int unsigned LEN = 4;
  localparam int unsigned NCH = 2;
  localparam int unsigned TOL = 1;
  localparam int unsigned OW  = 3;

  logic            clk = 1'b0;
  logic            reset_L;
  logic            fifo_wr;
  logic [0:0]      wr_ch;
  logic [BW-1:0]   fifo_data_in;
  logic            fifo_rd;
  logic [0:0]      rd_ch;
  logic [BW-1:0]   fifo_data_out;
  logic            data_valid;
  logic [NCH-1:0]  error_output, fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty;
  logic [NCH*OW-1:0] occupancy;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [BW-1:0]  q [NCH][$];
  logic [BW-1:0]  m_dout;
  logic           m_valid;
  logic [NCH-1:0] m_err;

  vc_fifo_bank #(.BW(BW), .LEN(LEN), .NCH(NCH), .TOL(TOL)) dut (
    .clk               (clk),
    .reset_L           (reset_L),
    .fifo_wr           (fifo_wr),
    .wr_ch             (wr_ch),
    .fifo_data_in      (fifo_data_in),
    .fifo_rd           (fifo_rd),
    .rd_ch             (rd_ch),
    .fifo_data_out     (fifo_data_out),
    .data_valid        (data_valid),
    .error_output      (error_output),
    .fifo_full         (fifo_full),
    .fifo_empty        (fifo_empty),
    .fifo_almost_full  (fifo_almost_full),
    .fifo_almost_empty (fifo_almost_empty),
    .occupancy         (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [NCH-1:0]    e_full, e_empty, e_af, e_ae;
    logic [NCH*OW-1:0] e_occ;
    for (int i = 0; i < NCH; i++) begin
      int n = q[i].size();
      e_full[i]  = (n == LEN);
      e_empty[i] = (n == 0);
      e_af[i]    = (n >= LEN - TOL);
      e_ae[i]    = (n <= TOL);
      e_occ[i*OW +: OW] = OW'(n);
    end
    chk("data_out",     32'(fifo_data_out),     32'(m_dout));
    chk("data_valid",   32'(data_valid),        32'(m_valid));
    chk("error",        32'(error_output),      32'(m_err));
    chk("full",         32'(fifo_full),         32'(e_full));
    chk("empty",        32'(fifo_empty),        32'(e_empty));
    chk("almost_full",  32'(fifo_almost_full),  32'(e_af));
    chk("almost_empty", 32'(fifo_almost_empty), 32'(e_ae));
    chk("occupancy",    32'(occupancy),         32'(e_occ));
  endtask

  // Drive one cycle, advance the model by the same rules, then check at the falling edge.
  task automatic step(input logic wr, input int wch, input logic [BW-1:0] din,
                      input logic rd, input int rch, input logic rst);
    bit rd_acc, wr_acc;
    fifo_wr      = wr;
    wr_ch        = 1'(wch);
    fifo_data_in = din;
    fifo_rd      = rd;
    rd_ch        = 1'(rch);
    reset_L      = !rst;
    if (rst) begin
      for (int i = 0; i < NCH; i++) q[i].delete();
      m_dout  = '0;
      m_valid = 1'b0;
      m_err   = '0;
    end else begin
      rd_acc = rd && (q[rch].size() > 0);
      wr_acc = wr && ((q[wch].size() < LEN) || (rd_acc && rch == wch));
      if (rd && !rd_acc) m_err[rch] = 1'b1;
      if (wr && !wr_acc) m_err[wch] = 1'b1;
      m_valid = rd_acc;
      if (rd_acc) m_dout = q[rch].pop_front();
      if (wr_acc) q[wch].push_back(din);
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    fifo_wr = 0; wr_ch = 0; fifo_data_in = 0; fifo_rd = 0; rd_ch = 0; reset_L = 0;
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 6'h11, 1, 1, 1);
    chk("reset_empty", 32'(fifo_empty), 32'h3);

    // Fill channel 0
    for (int k = 1; k <= 4; k++) begin
      step(1, 0, BW'(k), 0, 0, 0);
      chk("fill_occ0", 32'(occupancy[2:0]), 32'(k));
      chk("fill_af0",  32'(fifo_almost_full[0]), 32'(k >= 3));
      chk("fill_ch1",  32'({fifo_empty[1], fifo_almost_empty[1], occupancy[5:3]}), 32'h18);
    end
    chk("fill_full0", 32'(fifo_full[0]), 32'h1);

    // Drain in order
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, 0, 1, 0, 0);
      chk("drain_data",  32'(fifo_data_out), 32'(k));
      chk("drain_valid", 32'(data_valid), 32'h1);
    end
    step(0, 0, 0, 0, 0, 0);
    chk("drain_empty0", 32'(fifo_empty[0]), 32'h1);
    chk("hold_data",    32'(fifo_data_out), 32'h4);

    // Overflow then underflow
    for (int k = 1; k <= 4; k++) step(1, 0, BW'(k), 0, 0, 0);
    step(1, 0, 6'h3F, 0, 0, 0);
    chk("ovf_err", 32'(error_output), 32'h1);
    step(0, 0, 0, 1, 1, 0);
    chk("unf_err",   32'(error_output), 32'h3);
    chk("unf_valid", 32'(data_valid), 32'h0);

    // Simultaneous read/write on full channel, then wrap-around
    step(1, 0, 6'h2A, 1, 0, 0);
    chk("sim_data", 32'(fifo_data_out), 32'h1);
    chk("sim_occ",  32'(occupancy[2:0]), 32'h4);
    for (int k = 0; k < 6; k++) step(1, 0, BW'(6'h30 + k), 1, 0, 0);

    // Cross-channel
    step(1, 1, 6'h15, 1, 0, 0);
    chk("x_occ0", 32'(occupancy[2:0]), 32'h3);
    chk("x_occ1", 32'(occupancy[5:3]), 32'h1);

    // Mid-run reset with write pending
    step(1, 1, 6'h07, 0, 0, 0);
    step(1, 0, 6'h09, 0, 0, 1);
    chk("mrst_occ", 32'(occupancy), 32'h0);
    chk("mrst_err", 32'(error_output), 32'h0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 1)), BW'($urandom),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
           ($urandom_range(0, 63) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
